// File: rtl/reset_seq.sv
// Sequenced peripheral reset controller: holds selected resets, then releases
// them highest bit first with a programmable gap, pulsing irq_done at the end.
module reset_seq #(
  parameter int N_RST        = 10,
  parameter int POR_HOLD     = 16,
  parameter int HOLD_DEFAULT = 16,
  parameter int GAP_DEFAULT  = 4
) (
  input  logic             clk,
  input  logic             rst_globl,
  input  logic [1:0]       a,
  input  logic [31:0]      d,
  input  logic             we,
  output logic [31:0]      spo,
  output logic [N_RST-1:0] rst_out,
  output logic             busy,
  output logic             irq_done
);

  typedef enum logic [1:0] {
    S_IDLE, S_ASSERT, S_REL, S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      hold_q, hold_d;
  logic [15:0]      gap_q, gap_d;
  logic [N_RST-1:0] rst_q, rst_d;
  logic [N_RST-1:0] pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             irq_q, irq_d;

  logic [31:0]      wdata, rdata;
  logic [N_RST-1:0] mask, hi, pend_nx;
  logic [15:0]      hold_eff;
  logic             idle, start, rej;
  logic             unused_ok;

  assign wdata     = {d[7:0], d[15:8], d[23:16], d[31:24]};
  assign mask      = wdata[N_RST-1:0];
  assign unused_ok = ^wdata[29:16];
  assign idle      = (state_q == S_IDLE);
  assign hold_eff  = (hold_q == 16'd0) ? 16'd1 : hold_q;
  assign start     = we && (a == 2'd0) && wdata[31]
                     && idle && (|mask);
  // Anything but a plain ovr-clear is refused mid-sequence
  assign rej       = we && !idle
                     && ((a != 2'd0) || wdata[31]);

  always_comb begin
    hi = '0;
    for (int i = 0; i < N_RST; i++)
      if (pend_q[i]) begin
        hi    = '0;
        hi[i] = 1'b1;
      end
  end

  assign pend_nx = pend_q & ~hi;

  always_ff @(posedge clk or posedge rst_globl) begin
    if (rst_globl) begin
      state_q <= S_ASSERT;
      cnt_q   <= 16'(POR_HOLD);
      hold_q  <= 16'(HOLD_DEFAULT);
      gap_q   <= 16'(GAP_DEFAULT);
      rst_q   <= '1;
      pend_q  <= '1;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = S_ASSERT;
      S_ASSERT:
        if (cnt_q == 16'd1) state_d = S_REL;
      S_REL:
        if (pend_nx == '0) state_d = S_IDLE;
        else if (gap_q != 16'd0) state_d = S_GAP;
      S_GAP:
        if (cnt_q == 16'd1) state_d = S_REL;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    rst_d  = rst_q;
    pend_d = pend_q;
    irq_d  = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (start) begin
          rst_d  = rst_q | mask;
          pend_d = mask;
          cnt_d  = hold_eff;
        end else if (we && a == 2'd3) begin
          rst_d = mask;
        end
      S_ASSERT: cnt_d = cnt_q - 16'd1;
      S_REL: begin
        rst_d  = rst_q & ~hi;
        pend_d = pend_nx;
        if (pend_nx == '0) irq_d = 1'b1;
        else if (gap_q != 16'd0) cnt_d = gap_q;
      end
      S_GAP: cnt_d = cnt_q - 16'd1;
      default: ;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    gap_d  = gap_q;
    ovr_d  = ovr_q;
    if (we && idle && a == 2'd1) hold_d = wdata[15:0];
    if (we && idle && a == 2'd2) gap_d  = wdata[15:0];
    if (rej) ovr_d = 1'b1;
    else if (we && a == 2'd0 && wdata[30]) ovr_d = 1'b0;
  end

  always_comb begin
    busy     = !idle;
    rst_out  = rst_q;
    irq_done = irq_q;
    rdata    = '0;
    unique case (a)
      2'd0: rdata = {busy, ovr_q, {(30-N_RST){1'b0}}, rst_q};
      2'd1: rdata = {16'd0, hold_q};
      2'd2: rdata = {16'd0, gap_q};
      2'd3: rdata = {{(32-N_RST){1'b0}}, rst_q};
      default: ;
    endcase
    spo = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
  end

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: release-schedule model checked every cycle,
// plus pinned literal expectations for the directed scenarios.
module tb_reset_seq;

  logic        clk = 1'b0;
  logic        rst_globl;
  logic [1:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic [9:0]  rst_out;
  logic        busy;
  logic        irq_done;

  int errs = 0;
  int checks = 0;
  bit run = 0;

  reset_seq dut (
    .clk      (clk),
    .rst_globl(rst_globl),
    .a        (a),
    .d        (d),
    .we       (we),
    .spo      (spo),
    .rst_out  (rst_out),
    .busy     (busy),
    .irq_done (irq_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Model: a sequence is a list of absolute release cycles per bit
  logic [9:0]  m_rst = '1;
  logic [15:0] m_hold = 16'd16;
  logic [15:0] m_gap = 16'd4;
  bit          m_act = 1'b1;
  bit          m_ovr = 1'b0;
  bit          m_irq = 1'b0;
  bit          m_was;
  int          rel_at[10];
  int          m_end = 0;
  int          cyc = 0;
  logic [31:0] m_w;

  task automatic sched(input int base, input logic [15:0] h,
                       input logic [15:0] g, input logic [9:0] msk);
    int t;
    t = base + ((h == 16'd0) ? 1 : int'(h)) + 1;
    for (int b = 0; b < 10; b++) rel_at[b] = -1;
    for (int b = 9; b >= 0; b--)
      if (msk[b]) begin
        rel_at[b] = t;
        m_end = t;
        t = t + int'(g) + 1;
      end
    m_act = 1'b1;
  endtask

  always @(posedge clk or posedge rst_globl) begin
    if (rst_globl) begin
      m_rst  = '1;
      m_hold = 16'd16;
      m_gap  = 16'd4;
      m_ovr  = 1'b0;
      m_irq  = 1'b0;
      sched(cyc, 16'd16, 16'd4, 10'h3FF);
    end else begin
      cyc++;
      m_was = m_act;
      m_irq = 1'b0;
      if (m_act) begin
        for (int b = 0; b < 10; b++)
          if (rel_at[b] == cyc) begin
            m_rst[b]  = 1'b0;
            rel_at[b] = -1;
          end
        if (cyc == m_end) begin
          m_act = 1'b0;
          m_irq = 1'b1;
        end
      end
      if (we) begin
        m_w = sw(d);
        case (a)
          2'd0: begin
            if (m_was && m_w[31]) m_ovr = 1'b1;
            else if (m_w[30]) m_ovr = 1'b0;
            if (!m_was && m_w[31] && m_w[9:0] != 10'd0) begin
              m_rst = m_rst | m_w[9:0];
              sched(cyc, m_hold, m_gap, m_w[9:0]);
            end
          end
          2'd1: if (m_was) m_ovr = 1'b1; else m_hold = m_w[15:0];
          2'd2: if (m_was) m_ovr = 1'b1; else m_gap = m_w[15:0];
          default: if (m_was) m_ovr = 1'b1; else m_rst = m_w[9:0];
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (run && !rst_globl) begin
      chk("cyc_rst_out", {22'd0, rst_out}, {22'd0, m_rst});
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_act});
      chk("cyc_irq", {31'd0, irq_done}, {31'd0, m_irq});
    end
  end

  // data is given in register (swapped) order
  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    a  = addr;
    d  = sw(data);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp,
                    input string nm);
    a = addr;
    #1;
    chk(nm, spo, sw(exp));
  endtask

  initial begin
    a = 2'd0;
    d = 32'd0;
    we = 1'b0;
    rst_globl = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'd1, 32'd16, "rst_hold");
    rd(2'd2, 32'd4, "rst_gap");
    rd(2'd0, 32'h8000_03FF, "rst_ctrl");
    chk("rst_busy", {31'd0, busy}, 32'd1);
    rst_globl = 1'b0;
    run = 1'b1;

    repeat (16) @(negedge clk);
    chk("por_hold", {22'd0, rst_out}, 32'h3FF);
    @(negedge clk);
    chk("por_b9", {22'd0, rst_out}, 32'h1FF);
    repeat (5) @(negedge clk);
    chk("por_b8", {22'd0, rst_out}, 32'h0FF);
    repeat (40) @(negedge clk);
    chk("por_last", {22'd0, rst_out}, 32'h0);
    chk("por_irq", {31'd0, irq_done}, 32'd1);
    @(negedge clk);
    chk("por_irq_off", {31'd0, irq_done}, 32'd0);
    chk("por_idle", {31'd0, busy}, 32'd0);

    wr(2'd1, 32'd4);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h8000_0003);
    chk("s2_e0", {22'd0, rst_out}, 32'h3);
    repeat (4) @(negedge clk);
    chk("s2_e4", {22'd0, rst_out}, 32'h3);
    @(negedge clk);
    chk("s2_e5", {22'd0, rst_out}, 32'h1);
    repeat (2) @(negedge clk);
    chk("s2_e7", {22'd0, rst_out}, 32'h1);
    chk("s2_e7_irq", {31'd0, irq_done}, 32'd0);
    @(negedge clk);
    chk("s2_e8", {22'd0, rst_out}, 32'h0);
    chk("s2_e8_irq", {31'd0, irq_done}, 32'd1);
    @(negedge clk);

    wr(2'd2, 32'd0);
    wr(2'd0, 32'h8000_0205);
    repeat (5) @(negedge clk);
    chk("s3_e5", {22'd0, rst_out}, 32'h005);
    @(negedge clk);
    chk("s3_e6", {22'd0, rst_out}, 32'h001);
    @(negedge clk);
    chk("s3_e7", {22'd0, rst_out}, 32'h000);
    chk("s3_irq", {31'd0, irq_done}, 32'd1);
    @(negedge clk);

    wr(2'd2, 32'd2);
    wr(2'd0, 32'h8000_0003);
    wr(2'd0, 32'h8000_03FF);
    rd(2'd0, 32'hC000_0003, "s4_ovr_busy");
    repeat (12) @(negedge clk);
    rd(2'd0, 32'h4000_0000, "s4_ovr_idle");
    wr(2'd0, 32'h4000_0000);
    rd(2'd0, 32'h0, "s4_clr");

    wr(2'd3, 32'h010);
    chk("s5_force", {22'd0, rst_out}, 32'h010);
    chk("s5_busy", {31'd0, busy}, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h8000_0001);
    wr(2'd3, 32'h3FF);
    repeat (10) @(negedge clk);
    chk("s5_keep", {22'd0, rst_out}, 32'h010);
    rd(2'd0, 32'h4000_0010, "s5_ovr");
    wr(2'd0, 32'h4000_0000);

    wr(2'd1, 32'd0);
    wr(2'd0, 32'h8000_0100);
    chk("h0_e0", {22'd0, rst_out}, 32'h110);
    @(negedge clk);
    chk("h0_e1", {22'd0, rst_out}, 32'h110);
    @(negedge clk);
    chk("h0_e2", {22'd0, rst_out}, 32'h010);
    chk("h0_irq", {31'd0, irq_done}, 32'd1);
    @(negedge clk);

    wr(2'd1, 32'd4);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h8000_0003);
    repeat (6) @(negedge clk);
    #2;
    rst_globl = 1'b1;
    #1;
    chk("s6_async", {22'd0, rst_out}, 32'h3FF);
    chk("s6_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_globl = 1'b0;
    repeat (70) @(negedge clk);
    chk("s6_done", {22'd0, rst_out}, 32'h0);
    chk("s6_idle", {31'd0, busy}, 32'd0);
    rd(2'd1, 32'd16, "s6_hold");

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
